wb_rr_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the peripheral slave (LED/seg/switch/keypad/timer register block) between the CPU data port (m0) and a second master such as a debug or DMA port (m1).
Grants are round-robin and locked for the whole cycle (cyc). A bus-timeout watchdog aborts a stalled transfer with an error.
Sits between the masters and the peripheral decoder's slave port.

---
 rtl/wb_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant,
// cycle-locked ownership and a stalled-transfer timeout.
module wb_rr_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1,
        ABORT
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    logic            last;
    logic            last_nx;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nx;
    logic            err_first;
    logic            err_first_nx;

    // In ABORT the aborted master is remembered in last.
    logic own;
    logic own_cyc;
    logic own_stb;

    always_comb begin
        own     = (state == GNT1) || ((state == ABORT) && last);
        own_cyc = own ? m1_cyc_i : m0_cyc_i;
        own_stb = own ? m1_stb_i : m0_stb_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            to_cnt    <= '0;
            err_first <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            to_cnt    <= to_cnt_nx;
            err_first <= err_first_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        last_nx      = last;
        to_cnt_nx    = '0;
        err_first_nx = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nx = last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nx = GNT0;
                end else if (m1_cyc_i) begin
                    state_nx = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc) begin
                    state_nx = IDLE;
                    last_nx  = own;
                end else if (own_stb && !s_ack_i) begin
                    if (to_cnt == TO_LAST) begin
                        state_nx     = ABORT;
                        last_nx      = own;
                        err_first_nx = 1'b1;
                    end else begin
                        to_cnt_nx = to_cnt + 1'b1;
                    end
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                gnt_o    = 2'b10;
            end
            ABORT: begin
                m0_err_o = err_first && !last;
                m1_err_o = err_first && last;
            end
            default: begin
                gnt_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_wb_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_cyc = '0;
    logic [1:0]  m_stb = '0;
    logic [1:0]  m_we = '0;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_dato [2];
    logic [1:0]  m_ack;
    logic [1:0]  m_err;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i;
    logic [1:0]  gnt_o;
    logic        auto_ack = 1'b0;
    logic        ack_drv = 1'b0;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    // slave responder: either acks every strobe or follows ack_drv
    assign s_ack_i = auto_ack ? s_stb_o : ack_drv;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .m0_cyc_i(m_cyc[0]),
        .m0_stb_i(m_stb[0]),
        .m0_we_i(m_we[0]),
        .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_dat[0]),
        .m0_sel_i(m_sel[0]),
        .m0_dat_o(m_dato[0]),
        .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_cyc_i(m_cyc[1]),
        .m1_stb_i(m_stb[1]),
        .m1_we_i(m_we[1]),
        .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_dat[1]),
        .m1_sel_i(m_sel[1]),
        .m1_dat_o(m_dato[1]),
        .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o(s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: who owns the bus, whether it is being aborted,
    // who went last, and how many unacked strobes the owner has waited.
    int owner = -1;
    bit aborting = 1'b0;
    bit err_now = 1'b0;
    int last_m = 1;
    int waits = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= -1;
            aborting <= 1'b0;
            err_now  <= 1'b0;
            last_m   <= 1;
            waits    <= 0;
        end else if (aborting) begin
            err_now <= 1'b0;
            if (!m_cyc[last_m]) begin
                aborting <= 1'b0;
                owner    <= -1;
            end
        end else if (owner < 0) begin
            waits <= 0;
            if (m_cyc == 2'b11) owner <= 1 - last_m;
            else if (m_cyc[0]) owner <= 0;
            else if (m_cyc[1]) owner <= 1;
        end else if (!m_cyc[owner]) begin
            last_m <= owner;
            owner  <= -1;
            waits  <= 0;
        end else if (m_stb[owner] && !s_ack_i) begin
            if (waits + 1 >= TIMEOUT) begin
                aborting <= 1'b1;
                err_now  <= 1'b1;
                last_m   <= owner;
                waits    <= 0;
            end else begin
                waits <= waits + 1;
            end
        end else begin
            waits <= 0;
        end
    end

    logic        e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat, e_d0, e_d1;
    logic [3:0]  e_sel;
    logic [1:0]  e_gnt, e_ack, e_err;

    always @(negedge clk) begin
        if (run_chk) begin
            e_cyc = 0; e_stb = 0; e_we = 0;
            e_adr = 0; e_dat = 0; e_sel = 0;
            e_d0 = 0; e_d1 = 0;
            e_gnt = 0; e_ack = 0; e_err = 0;
            if (aborting) begin
                e_err[last_m] = err_now;
            end else if (owner >= 0) begin
                e_cyc = m_cyc[owner];
                e_stb = m_stb[owner];
                e_we  = m_we[owner];
                e_adr = m_adr[owner];
                e_dat = m_dat[owner];
                e_sel = m_sel[owner];
                e_gnt[owner] = 1'b1;
                e_ack[owner] = s_ack_i;
                if (owner == 0) e_d0 = s_dat_i;
                else e_d1 = s_dat_i;
            end
            chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
            chk("s_stb", 32'(s_stb_o), 32'(e_stb));
            chk("s_we", 32'(s_we_o), 32'(e_we));
            chk("s_adr", s_adr_o, e_adr);
            chk("s_dat", s_dat_o, e_dat);
            chk("s_sel", 32'(s_sel_o), 32'(e_sel));
            chk("gnt", 32'(gnt_o), 32'(e_gnt));
            chk("m_ack", 32'(m_ack), 32'(e_ack));
            chk("m_err", 32'(m_err), 32'(e_err));
            chk("m0_dat", m_dato[0], e_d0);
            chk("m1_dat", m_dato[1], e_d1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int done [2];
    bit ackd [2];
    bit dropped [2];
    int order [$];
    int stbn;
    int errn;
    int post;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0;
            m_dat[i] = '0;
            m_sel[i] = '0;
        end
        tick();
        run_chk = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_scyc", 32'(s_cyc_o), 0);
        chk("rst_ack", 32'(m_ack), 0);
        tick();
        rst = 1'b0;

        // single master write
        tick();
        m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1;
        m_adr[0] = 32'hF000; m_dat[0] = 32'hA5; m_sel[0] = 4'hF;
        auto_ack = 1;
        #1 chk("t1_pre_cyc", 32'(s_cyc_o), 0);
        tick();
        #1;
        chk("t1_cyc", 32'(s_cyc_o), 1);
        chk("t1_dat", s_dat_o, 32'hA5);
        chk("t1_adr", s_adr_o, 32'hF000);
        chk("t1_ack0", 32'(m_ack[0]), 1);
        chk("t1_ack1", 32'(m_ack[1]), 0);
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0; m_we[0] = 0;
        #1 chk("t1_ack_end", 32'(m_ack[0]), 0);
        tick();

        // simultaneous request after reset
        rst = 1;
        tick();
        rst = 0;
        m_cyc = 2'b11;
        #1 chk("t2_gnt_a", 32'(gnt_o), 0);
        tick();
        #1 chk("t2_gnt_b", 32'(gnt_o), 32'h1);
        m_cyc[0] = 0;
        tick();
        #1 chk("t2_gnt_c", 32'(gnt_o), 0);
        tick();
        #1 chk("t2_gnt_d", 32'(gnt_o), 32'h2);
        m_cyc[1] = 0;
        tick();

        // fairness: four single-beat reads each
        m_adr[0] = 32'hF020; m_adr[1] = 32'hF020;
        s_dat_i = 32'h5A; auto_ack = 1;
        m_cyc = 2'b11; m_stb = 2'b11;
        done[0] = 0; done[1] = 0;
        for (int c = 0; c < 200 && (done[0] < 4 || done[1] < 4); c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                if (dropped[m]) begin
                    dropped[m] = 0;
                    if (done[m] < 4) begin
                        m_cyc[m] = 1; m_stb[m] = 1;
                    end
                end else if (ackd[m]) begin
                    ackd[m] = 0; dropped[m] = 1;
                    m_cyc[m] = 0; m_stb[m] = 0;
                end
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m]) begin
                    ackd[m] = 1;
                    done[m]++;
                    order.push_back(m);
                    chk("fair_dat", m_dato[m], 32'h5A);
                end
            end
        end
        chk("fair_len", order.size(), 8);
        for (int i = 0; i < order.size(); i++)
            chk("fair_order", order[i], i % 2);
        tick();
        m_cyc = 0; m_stb = 0;
        ackd[0] = 0; ackd[1] = 0; dropped[0] = 0; dropped[1] = 0;
        tick();
        tick();

        // locked burst by m1
        m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 32'hF010;
        #1 chk("t4_gnt_idle", 32'(gnt_o), 0);
        tick();
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'hBEEF;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) tick();
            #1;
            chk("t4_gnt", 32'(gnt_o), 32'h2);
            chk("t4_adr", s_adr_o, 32'hF010);
            chk("t4_ack1", 32'(m_ack[1]), 1);
            chk("t4_ack0", 32'(m_ack[0]), 0);
        end
        tick();
        m_cyc[1] = 0; m_stb[1] = 0;
        tick();
        #1 chk("t4_turn", 32'(gnt_o), 0);
        tick();
        #1;
        chk("t4_gnt0", 32'(gnt_o), 32'h1);
        chk("t4_adr0", s_adr_o, 32'hBEEF);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0;
        tick();
        tick();

        // timeout on m0
        auto_ack = 0; ack_drv = 0;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h1234;
        stbn = 0; errn = 0; post = 0;
        for (int c = 0; c < 60 && post < 4; c++) begin
            tick();
            #1;
            if (s_stb_o) stbn++;
            if (m_err[0]) begin
                errn++;
                chk("to_scyc", 32'(s_cyc_o), 0);
            end
            if (errn > 0) post++;
        end
        chk("to_stb_cycles", stbn, 16);
        chk("to_err_cycles", errn, 1);
        tick();
        m_cyc[0] = 0; m_stb[0] = 0;
        m_cyc[1] = 1; m_stb[1] = 1; auto_ack = 1;
        tick();
        #1 chk("to_idle", 32'(gnt_o), 0);
        tick();
        #1 chk("to_m1_gnt", 32'(gnt_o), 32'h2);
        tick();
        m_cyc[1] = 0; m_stb[1] = 0;
        tick();
        tick();

        // ack on the 16th wait cycle wins
        auto_ack = 0; ack_drv = 0;
        m_cyc[0] = 1; m_stb[0] = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) ack_drv = 1;
            #1;
            if (k == 16) begin
                chk("b16_ack", 32'(m_ack[0]), 1);
                chk("b16_err", 32'(m_err[0]), 0);
            end
        end
        tick();
        ack_drv = 0;
        #1;
        chk("b16_gnt", 32'(gnt_o), 32'h1);
        chk("b16_noerr", 32'(m_err[0]), 0);
        m_cyc[0] = 0; m_stb[0] = 0;
        tick();
        tick();

        // asynchronous reset mid-grant
        m_cyc[0] = 1; m_stb[0] = 1; m_dat[0] = 32'h77;
        tick();
        ack_drv = 1;
        #1 chk("rg_gnt", 32'(gnt_o), 32'h1);
        #1 rst = 1;
        #1;
        chk("rg_gnt0", 32'(gnt_o), 0);
        chk("rg_scyc", 32'(s_cyc_o), 0);
        chk("rg_sdat", s_dat_o, 0);
        chk("rg_ack", 32'(m_ack), 0);
        chk("rg_err", 32'(m_err), 0);
        tick();
        rst = 0; ack_drv = 0;
        m_cyc = 2'b11; m_stb = 2'b00;
        tick();
        #1 chk("rg_tie", 32'(gnt_o), 32'h1);
        m_cyc = 0;
        tick();
        tick();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = 0;
            auto_ack = 0;
            if (((c / 256) % 2) == 1)
                ack_drv = ($urandom_range(0, 49) == 0);
            else
                ack_drv = ($urandom_range(0, 2) == 0);
            s_dat_i = $urandom;
            for (int m = 0; m < 2; m++) begin
                if (m_cyc[m]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc[m] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc[m] = 1;
                end
                m_stb[m] = m_cyc[m] && ($urandom_range(0, 9) < 8);
                m_we[m]  = 1'($urandom);
                m_adr[m] = $urandom;
                m_dat[m] = $urandom;
                m_sel[m] = 4'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
            end
        end
        tick();
        rst = 0;
        m_cyc = 0; m_stb = 0;
        tick();
        tick();
        run_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
